// File: rtl/dloop_seq_pkg.sv
// dloop_seq_pkg: opcodes, FSM states, instruction field positions and control bundle for dloop_sequencer.
package dloop_seq_pkg;
  localparam int REG_AW = 4;
  localparam int OP_W = 4;
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RC_MSB = 11;
  localparam int RC_LSB = 8;
  localparam int RA_MSB = 7;
  localparam int RA_LSB = 4;
  localparam int RB_MSB = 3;
  localparam int RB_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_OR   = 4'h3,
    OP_ADDI = 4'h4,
    OP_LDI  = 4'h5,
    OP_CMP  = 4'h6,
    OP_MOV  = 4'h7,
    OP_JMP  = 4'h8,
    OP_BZ   = 4'h9,
    OP_BC   = 4'hA,
    OP_HALT = 4'hF
  } opcode_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED
  } state_e;
  typedef struct packed {
    logic en_a;
    logic imm_en_a;
    logic inv_a;
    logic en_b;
    logic imm_en_b;
    logic inv_b;
    logic c_in;
    logic or_en;
    logic flood_carry;
    logic reg_write_en;
    logic ra_from_rc;
    logic latch_flags;
    logic jmp;
    logic bz;
    logic bc;
    logic halt;
  } ctrl_t;
endpackage

// File: rtl/dloop_seq_decode.sv
// dloop_seq_decode: opcode to control bundle; BZ/BC decode only with DLOOP_SEQUENCER_BRANCH_EN.
module dloop_seq_decode
  import dloop_seq_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output ctrl_t           ctrl
);
  always_comb begin
    ctrl = '0;
    ctrl.en_a = op inside {OP_ADD, OP_SUB, OP_OR, OP_ADDI, OP_CMP, OP_MOV};
    ctrl.en_b = op inside {OP_ADD, OP_SUB, OP_OR, OP_CMP};
    ctrl.inv_b = op inside {OP_SUB, OP_CMP};
    ctrl.c_in = op inside {OP_SUB, OP_CMP};
    ctrl.or_en = op == OP_OR;
    ctrl.imm_en_b = op inside {OP_ADDI, OP_LDI};
    ctrl.reg_write_en = op inside {OP_ADD, OP_SUB, OP_OR, OP_ADDI, OP_LDI, OP_MOV};
    ctrl.ra_from_rc = op == OP_ADDI;
    ctrl.latch_flags = op inside {OP_ADD, OP_SUB, OP_OR, OP_ADDI, OP_LDI, OP_CMP, OP_MOV};
    ctrl.jmp = op == OP_JMP;
`ifdef DLOOP_SEQUENCER_BRANCH_EN
    ctrl.bz = op == OP_BZ;
    ctrl.bc = op == OP_BC;
`else
    ctrl.bz = 1'b0;
    ctrl.bc = 1'b0;
`endif
    ctrl.halt = op == OP_HALT;
  end
endmodule

// File: rtl/dloop_sequencer.sv
// dloop_sequencer: fetch/exec micro-sequencer driving datapath control lines.
// Conditional branches BZ/BC are enabled by defining DLOOP_SEQUENCER_BRANCH_EN.
module dloop_sequencer
  import dloop_seq_pkg::*;
#(
  parameter int BitWidth = 8,
  parameter int PCWidth  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                start,
  output logic                imem_req,
  output logic [PCWidth-1:0]  imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_data,
  input  logic                cOut,
  input  logic                ifZero,
  input  logic                overflow,
  output logic                EnA,
  output logic                ImmEnA,
  output logic                InvA,
  output logic                EnB,
  output logic                ImmEnB,
  output logic                InvB,
  output logic                cIn,
  output logic                ORen,
  output logic                FloodCarry,
  output logic                RegWriteEn,
  output logic                OutputOverrideEnable,
  output logic [REG_AW-1:0]   regAAddr,
  output logic [REG_AW-1:0]   regBAddr,
  output logic [REG_AW-1:0]   regCAddr,
  output logic [BitWidth-1:0] ImmIN,
  output logic                busy,
  output logic                halted
);
  state_e state_q, state_d;
  logic [PCWidth-1:0] pc_q, pc_d, imem_addr_q, imem_addr_d;
  logic [15:0] ir_q, ir_d;
  logic z_q, z_d, c_q, c_d;
  logic imem_req_q, imem_req_d, busy_q, busy_d, halted_q, halted_d;
  logic exec, taken, unused;
  logic [7:0] imm8;
  ctrl_t dec, ctl;
  dloop_seq_decode u_decode (
    .op  (ir_q[OP_MSB:OP_LSB]),
    .ctrl(dec)
  );
  assign exec = state_q == S_EXEC;
  assign imm8 = ir_q[IMM_MSB:IMM_LSB];
  assign taken = dec.jmp | (dec.bz & z_q) | (dec.bc & c_q);
  assign unused = overflow;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    z_d = z_q;
    c_d = c_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        state_d = start ? S_FETCH : state_q;
        pc_d = start ? '0 : pc_q;
      end
      S_FETCH: begin
        state_d = imem_ack ? S_EXEC : S_FETCH;
        ir_d = imem_ack ? imem_data : ir_q;
      end
      S_EXEC: begin
        state_d = dec.halt ? S_HALTED : S_FETCH;
        pc_d = dec.halt ? pc_q : taken ? PCWidth'(imm8) : pc_q + PCWidth'(1);
        z_d = dec.latch_flags ? ifZero : z_q;
        c_d = dec.latch_flags ? cOut : c_q;
      end
      default: state_d = S_IDLE;
    endcase
    imem_req_d = state_d == S_FETCH;
    imem_addr_d = imem_req_d ? pc_d : '0;
    busy_d = imem_req_d | (state_d == S_EXEC);
    halted_d = state_d == S_HALTED;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      ir_q <= '0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      imem_req_q <= 1'b0;
      imem_addr_q <= '0;
      busy_q <= 1'b0;
      halted_q <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      z_q <= z_d;
      c_q <= c_d;
      imem_req_q <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      busy_q <= busy_d;
      halted_q <= halted_d;
    end
  end
  // Control lines only ever reflect the latched instruction while executing it.
  assign ctl = exec ? dec : '0;
  assign EnA = ctl.en_a;
  assign ImmEnA = ctl.imm_en_a;
  assign InvA = ctl.inv_a;
  assign EnB = ctl.en_b;
  assign ImmEnB = ctl.imm_en_b;
  assign InvB = ctl.inv_b;
  assign cIn = ctl.c_in;
  assign ORen = ctl.or_en;
  assign FloodCarry = ctl.flood_carry;
  assign RegWriteEn = ctl.reg_write_en;
  assign OutputOverrideEnable = 1'b0;
  assign regCAddr = exec ? ir_q[RC_MSB:RC_LSB] : '0;
  assign regAAddr = exec ? (dec.ra_from_rc ? ir_q[RC_MSB:RC_LSB] : ir_q[RA_MSB:RA_LSB]) : '0;
  assign regBAddr = exec ? ir_q[RB_MSB:RB_LSB] : '0;
  assign ImmIN = exec ? BitWidth'(imm8) : '0;
  assign imem_req = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign busy = busy_q;
  assign halted = halted_q;
endmodule

// File: tb/tb_dloop_sequencer.sv
// tb_dloop_sequencer: directed program run with a fetch-address scoreboard.
module tb_dloop_sequencer;
  localparam bit BR =
`ifdef DLOOP_SEQUENCER_BRANCH_EN
    1'b1;
`else
    1'b0;
`endif
  localparam logic [10:0] EA = 11'h400, IEA = 11'h200, IVA = 11'h100, EB = 11'h080, IEB = 11'h040;
  localparam logic [10:0] IVB = 11'h020, CI = 11'h010, ORE = 11'h008, FC = 11'h004, WE = 11'h002;
  logic clk = 0, rst_n = 0, clk_en = 1, start = 0, imem_ack = 0, cOut = 0, ifZero = 0, overflow = 0;
  logic [15:0] imem_data = '0;
  logic imem_req, busy, halted;
  logic [7:0] imem_addr, ImmIN;
  logic EnA, ImmEnA, InvA, EnB, ImmEnB, InvB, cIn, ORen, FloodCarry, RegWriteEn, OutputOverrideEnable;
  logic [3:0] regAAddr, regBAddr, regCAddr;
  logic [10:0] ctrl_v;
  logic [7:0] sb[$];
  logic [7:0] p, a;
  int checks = 0, errors = 0;
  dloop_sequencer dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .cOut(cOut), .ifZero(ifZero), .overflow(overflow),
    .EnA(EnA), .ImmEnA(ImmEnA), .InvA(InvA), .EnB(EnB), .ImmEnB(ImmEnB), .InvB(InvB),
    .cIn(cIn), .ORen(ORen), .FloodCarry(FloodCarry), .RegWriteEn(RegWriteEn),
    .OutputOverrideEnable(OutputOverrideEnable),
    .regAAddr(regAAddr), .regBAddr(regBAddr), .regCAddr(regCAddr), .ImmIN(ImmIN),
    .busy(busy), .halted(halted)
  );
  assign ctrl_v = {EnA, ImmEnA, InvA, EnB, ImmEnB, InvB, cIn, ORen, FloodCarry, RegWriteEn, OutputOverrideEnable};
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  function automatic logic [10:0] exp_ctrl(input logic [3:0] op);
    case (op)
      4'h1: return EA | EB | WE;
      4'h2: return EA | EB | IVB | CI | WE;
      4'h3: return EA | EB | ORE | WE;
      4'h4: return EA | IEB | WE;
      4'h5: return IEB | WE;
      4'h6: return EA | EB | IVB | CI;
      4'h7: return EA | WE;
      default: return 11'h000;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic exec_chk(input logic [15:0] ins);
    logic [3:0] op;
    op = ins[15:12];
    chk("exec_busy", busy, 1);
    chk("exec_req", imem_req, 0);
    chk($sformatf("ctrl_op%0h", op), ctrl_v, exp_ctrl(op));
    if (op inside {[4'h1:4'h7]}) begin
      chk("regC", regCAddr, ins[11:8]);
      chk("regA", regAAddr, op == 4'h4 ? ins[11:8] : ins[7:4]);
      chk("regB", regBAddr, ins[3:0]);
    end
    if (op == 4'h4 || op == 4'h5) chk("imm", ImmIN, ins[7:0]);
  endtask
  task automatic fetch(input logic [15:0] ins, input int dly);
    int n;
    logic [7:0] ea;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    cOut = 0;
    ifZero = 0;
    chk("fetch_req", imem_req, 1);
    chk("sb_pending", sb.size() != 0, 1);
    ea = sb.size() != 0 ? sb.pop_front() : 8'hxx;
    chk("fetch_addr", imem_addr, ea);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("hold_req", imem_req, 1);
      chk("hold_addr", imem_addr, ea);
      chk("hold_ctrl", ctrl_v, 0);
    end
    imem_ack = 1;
    imem_data = ins;
    @(negedge clk);
    imem_ack = 0;
    imem_data = '0;
    exec_chk(ins);
  endtask
  task automatic run(input logic [15:0] ins, input int dly, input logic z, input logic c, input logic [7:0] nxt);
    fetch(ins, dly);
    ifZero = z;
    cOut = c;
    sb.push_back(nxt);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_ctrl", ctrl_v, 0);
    chk("rst_regs", {regAAddr, regBAddr, regCAddr, ImmIN}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    sb.push_back(8'h00);
    run(16'h5105, 0, 0, 0, 8'h01);
    run(16'h2211, 0, 1, 0, 8'h02);
    p = BR ? 8'h40 : 8'h03;
    run(16'h9040, 0, 0, 0, p);
    run(16'h1345, 3, 0, 1, p + 8'h01);
    p = BR ? 8'h80 : p + 8'h02;
    run(16'hA080, 0, 0, 0, p);
    run(16'h80FF, 0, 0, 0, 8'hFF);
    run(16'h0000, 0, 0, 0, 8'h00);
    run(16'h4307, 0, 0, 0, 8'h01);
    run(16'h6012, 0, 0, 0, 8'h02);
    run(16'h3123, 0, 0, 0, 8'h03);
    run(16'h7450, 0, 0, 0, 8'h04);
    fetch(16'hF000, 0);
    @(negedge clk);
    chk("halt_halted", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_req", imem_req, 0);
    clk_en = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    clk_en = 1;
    chk("clken_hold", halted, 1);
    start = 1;
    @(negedge clk);
    start = 0;
    sb.push_back(8'h00);
    chk("restart_req", imem_req, 1);
    a = sb.pop_front();
    chk("restart_addr", imem_addr, a);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    imem_ack = 1;
    imem_data = 16'h5105;
    @(negedge clk);
    chk("abort_req", imem_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ctrl", ctrl_v, 0);
    imem_ack = 0;
    imem_data = '0;
    @(negedge clk);
    chk("abort_noexec", {busy, halted, ctrl_v}, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
